// File: rtl/alu_stage.sv
// alu_stage: registered Hack-style ALU with a 2-entry result queue and
// valid/ready handshakes on both the operand side and the writeback side.

// Existing 16-bit bitwise AND block, reused as the f=0 path of the ALU.
module and16 (
    input  logic [15:0] a,
    input  logic [15:0] b,
    output logic [15:0] y
);

    assign y = a & b;

endmodule

module alu_stage #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inValid,
    output logic             inReady,
    input  logic [WIDTH-1:0] inA,
    input  logic [WIDTH-1:0] inB,
    input  logic [5:0]       ctrl,
    output logic             outValid,
    input  logic             outReady,
    output logic [WIDTH-1:0] out,
    output logic             zr,
    output logic             ng
);

    // Control word fields
    logic zx, nx, zy, ny, fn, no;
    assign {zx, nx, zy, ny, fn, no} = ctrl;

    // Datapath signals
    logic [WIDTH-1:0] x1, x2, y1, y2;
    logic [WIDTH-1:0] and_r, sum_r, r, o;

    // Queue entries hold {result, zero flag, negative flag}; entry0 is the head
    logic [WIDTH+1:0] entry_new;
    logic [WIDTH+1:0] entry0;
    logic [WIDTH+1:0] entry1;
    logic [1:0]       count;
    logic             push, pop;

    and16 u_and (
        .a (x2),
        .b (y2),
        .y (and_r)
    );

    // Hack function on the operands currently offered; only stored when pushed
    always_comb begin
        x1        = zx ? '0 : inA;
        x2        = nx ? ~x1 : x1;
        y1        = zy ? '0 : inB;
        y2        = ny ? ~y1 : y1;
        sum_r     = x2 + y2;
        r         = fn ? sum_r : and_r;
        o         = no ? ~r : r;
        entry_new = {o, (o == '0), o[WIDTH-1]};
    end

    // Handshake status depends only on the registered occupancy
    assign inReady  = (count != 2'd2);
    assign outValid = (count != 2'd0);
    assign push     = inValid && inReady;
    assign pop      = outValid && outReady;

    // Head drives the outputs, which read as zero while the queue is empty
    assign out = outValid ? entry0[WIDTH+1:2] : '0;
    assign zr  = outValid & entry0[1];
    assign ng  = outValid & entry0[0];

    // FIFO update; simultaneous push and pop only happens with one entry held,
    // in which case the new result replaces the departing head directly
    always_ff @(posedge clk) begin
        if (reset) begin
            count  <= 2'd0;
            entry0 <= '0;
            entry1 <= '0;
        end else if (push && pop) begin
            entry0 <= entry_new;
        end else if (push) begin
            if (count == 2'd0) begin
                entry0 <= entry_new;
            end else begin
                entry1 <= entry_new;
            end
            count <= count + 2'd1;
        end else if (pop) begin
            entry0 <= entry1;
            entry1 <= '0;
            count  <= count - 2'd1;
        end
    end

endmodule

// File: tb/tb_alu_stage.sv
// tb_alu_stage: drives alu_stage with directed and random traffic and
// compares every cycle against a queue-based reference model.

module tb_alu_stage;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        inValid = 1'b0;
    logic        inReady;
    logic [15:0] inA = '0;
    logic [15:0] inB = '0;
    logic [5:0]  ctrl = '0;
    logic        outValid;
    logic        outReady = 1'b0;
    logic [15:0] out;
    logic        zr;
    logic        ng;

    int checks = 0;
    int errors = 0;

    // Expected queue contents, oldest first: {result, zr, ng}
    logic [17:0] model_q[$];

    alu_stage #(.WIDTH(16)) dut (
        .clk      (clk),
        .reset    (reset),
        .inValid  (inValid),
        .inReady  (inReady),
        .inA      (inA),
        .inB      (inB),
        .ctrl     (ctrl),
        .outValid (outValid),
        .outReady (outReady),
        .out      (out),
        .zr       (zr),
        .ng       (ng)
    );

    // Free-running clock
    always #5 clk = ~clk;

    // Safety net so the run always ends
    initial begin
        #500000;
        $display("[TB] FAIL timeout: got running, expected finished");
        $fatal(1, "[TB] timeout");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
        end
    endtask

    // Reference function written with integer arithmetic: NOT is 65535 - v
    function automatic logic [17:0] refAlu(input logic [15:0] a, input logic [15:0] b,
                                           input logic [5:0] c);
        int unsigned xv, yv, rv;
        xv = c[5] ? 0 : int'(a);
        if (c[4]) xv = 65535 - xv;
        yv = c[3] ? 0 : int'(b);
        if (c[2]) yv = 65535 - yv;
        rv = c[1] ? (xv + yv) % 65536 : (xv & yv);
        if (c[0]) rv = 65535 - rv;
        return {rv[15:0], (rv == 0), (rv >= 32768)};
    endfunction

    task automatic compareModel();
        logic [17:0] head;
        head = (model_q.size() != 0) ? model_q[0] : 18'h0;
        checkOutput("outValid", outValid, model_q.size() != 0);
        checkOutput("inReady", inReady, model_q.size() < 2);
        checkOutput("out", out, head[17:2]);
        checkOutput("zr", zr, head[1]);
        checkOutput("ng", ng, head[0]);
    endtask

    // Applies one cycle of inputs, checks the pre-edge state, then advances
    task automatic applyStimulus(input logic v, input logic [15:0] a, input logic [15:0] b,
                                 input logic [5:0] c, input logic ordy);
        logic        do_push, do_pop;
        logic [17:0] entry;
        inValid  = v;
        inA      = a;
        inB      = b;
        ctrl     = c;
        outReady = ordy;
        #1;
        compareModel();
        do_push = v && (model_q.size() < 2);
        do_pop  = (model_q.size() != 0) && ordy;
        entry   = refAlu(a, b, c);
        @(posedge clk);
        #1;
        if (do_pop) void'(model_q.pop_front());
        if (do_push) model_q.push_back(entry);
    endtask

    task automatic doReset(input int cycles);
        reset    = 1'b1;
        inValid  = 1'b1;
        outReady = 1'b1;
        inA      = 16'h1234;
        inB      = 16'h4321;
        ctrl     = 6'b000010;
        for (int i = 0; i < cycles; i++) begin
            @(posedge clk);
            #1;
            model_q.delete();
            checkOutput("rst_outValid", outValid, 0);
            checkOutput("rst_inReady", inReady, 1);
            checkOutput("rst_out", out, 0);
            checkOutput("rst_zr", zr, 0);
            checkOutput("rst_ng", ng, 0);
        end
        reset   = 1'b0;
        inValid = 1'b0;
    endtask

    initial begin
        doReset(2);
        compareModel();

        // AND path
        applyStimulus(1, 16'h3CC3, 16'h0FF0, 6'b000000, 1);
        checkOutput("and_out", out, 16'h0CC0);
        checkOutput("and_zr", zr, 0);
        checkOutput("and_ng", ng, 0);
        checkOutput("and_valid", outValid, 1);
        applyStimulus(0, 16'h0, 16'h0, 6'b000000, 1);
        checkOutput("and_one_cycle", outValid, 0);

        // Add with wrap to zero
        applyStimulus(1, 16'hFFFF, 16'h0001, 6'b000010, 1);
        checkOutput("wrap_out", out, 16'h0000);
        checkOutput("wrap_zr", zr, 1);
        checkOutput("wrap_ng", ng, 0);

        // x - y going negative
        applyStimulus(1, 16'h0005, 16'h0007, 6'b010011, 1);
        checkOutput("sub_out", out, 16'hFFFE);
        checkOutput("sub_zr", zr, 0);
        checkOutput("sub_ng", ng, 1);
        applyStimulus(0, 16'h0, 16'h0, 6'b000000, 1);

        // Backpressure and ordering (y equals x so the pass-through is unambiguous)
        applyStimulus(1, 16'h0001, 16'h0001, 6'b110000, 0);
        applyStimulus(1, 16'h0002, 16'h0002, 6'b110000, 0);
        checkOutput("bp_full_ready", inReady, 0);
        applyStimulus(1, 16'h0003, 16'h0003, 6'b110000, 0);
        checkOutput("bp_hold_ready", inReady, 0);
        checkOutput("bp_hold_out", out, 16'h0001);
        applyStimulus(1, 16'h0003, 16'h0003, 6'b110000, 1);
        checkOutput("bp_ready_back", inReady, 1);
        checkOutput("bp_second", out, 16'h0002);
        applyStimulus(1, 16'h0003, 16'h0003, 6'b110000, 1);
        checkOutput("bp_third", out, 16'h0003);
        applyStimulus(0, 16'h0, 16'h0, 6'b000000, 1);
        checkOutput("bp_drained", outValid, 0);

        // Reset with the queue full
        applyStimulus(1, 16'h00AA, 16'h0055, 6'b000010, 0);
        applyStimulus(1, 16'h00BB, 16'h0044, 6'b000010, 0);
        checkOutput("mid_full", inReady, 0);
        doReset(1);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(0, 16'h0, 16'h0, 6'b000000, 1);
            checkOutput("mid_gone", outValid, 0);
        end

        // Random traffic against the model
        for (int i = 0; i < 400; i++) begin
            applyStimulus($urandom_range(0, 3) != 0, 16'($urandom), 16'($urandom),
                          6'($urandom), $urandom_range(0, 2) != 0);
        end
        for (int i = 0; i < 3; i++) begin
            applyStimulus(0, 16'h0, 16'h0, 6'b000000, 1);
        end
        compareModel();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
